// File: rtl/sfx_pkg.sv
// Shared types and note-table constants for the sound-effect sequencer.
package sfx_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned HP_W     = 19;
    localparam int unsigned SEG_W    = 24;
    localparam int unsigned IDX_W    = 2;

    typedef enum logic [1:0] {
        FX_NONE = 2'd0,
        FX_EAT  = 2'd1,
        FX_OVER = 2'd2
    } fx_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Note frequencies in Hz
    localparam int unsigned F_C6 = 1047;
    localparam int unsigned F_E6 = 1319;
    localparam int unsigned F_G4 = 392;
    localparam int unsigned F_E4 = 330;
    localparam int unsigned F_C4 = 262;
    localparam int unsigned F_C3 = 131;

    // Per-note duration and note count of each effect
    localparam int unsigned EAT_MS     = 60;
    localparam int unsigned OVER_MS    = 150;
    localparam int unsigned EAT_NOTES  = 2;
    localparam int unsigned OVER_NOTES = 4;

    // Rounded half-period in clock cycles for a tone of freq Hz
    function automatic int unsigned hp_cycles(input int unsigned clk_hz, input int unsigned freq);
        return (clk_hz + freq) / (2 * freq);
    endfunction

endpackage

// File: rtl/sfx_player_tone_gen.sv
// Square-wave phase generator: toggles phase every half_period cycles while enabled.
module tone_gen
    import sfx_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [HP_W-1:0] half_period,
    input  logic            restart,
    input  logic            enable,
    output logic            phase
);

    logic [HP_W-1:0] hp_cnt;

    // Half-period counter; restart forces phase high and a fresh count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_cnt <= '0;
            phase  <= 1'b0;
        end else if (restart) begin
            hp_cnt <= half_period - HP_W'(1);
            phase  <= 1'b1;
        end else if (enable) begin
            if (hp_cnt == '0) begin
                hp_cnt <= half_period - HP_W'(1);
                phase  <= ~phase;
            end else begin
                hp_cnt <= hp_cnt - HP_W'(1);
            end
        end
    end

endmodule

// File: rtl/sfx_player.sv
// Sound-effect sequencer: turns trigger pulses into timed square-wave note sequences.
module sfx_player
    import sfx_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter logic [15:0] AMPLITUDE = 16'h1FFF,
    parameter int unsigned GAP_MS    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trig_eat,
    input  logic        trig_over,
    input  logic        mute,
    output logic [15:0] audio_left,
    output logic [15:0] audio_right,
    output logic        busy
);

    localparam int unsigned CYC_PER_MS = CLK_HZ / 1000;

    // Segment counter reload values (count down to zero inclusive)
    localparam logic [SEG_W-1:0] SEG_EAT  = SEG_W'(EAT_MS * CYC_PER_MS - 1);
    localparam logic [SEG_W-1:0] SEG_OVER = SEG_W'(OVER_MS * CYC_PER_MS - 1);
    localparam logic [SEG_W-1:0] SEG_GAP  = SEG_W'(GAP_MS * CYC_PER_MS - 1);

    localparam logic [HP_W-1:0] HP_C6 = HP_W'(hp_cycles(CLK_HZ, F_C6));
    localparam logic [HP_W-1:0] HP_E6 = HP_W'(hp_cycles(CLK_HZ, F_E6));
    localparam logic [HP_W-1:0] HP_G4 = HP_W'(hp_cycles(CLK_HZ, F_G4));
    localparam logic [HP_W-1:0] HP_E4 = HP_W'(hp_cycles(CLK_HZ, F_E4));
    localparam logic [HP_W-1:0] HP_C4 = HP_W'(hp_cycles(CLK_HZ, F_C4));
    localparam logic [HP_W-1:0] HP_C3 = HP_W'(hp_cycles(CLK_HZ, F_C3));

    localparam logic [IDX_W-1:0] LAST_EAT  = IDX_W'(EAT_NOTES - 1);
    localparam logic [IDX_W-1:0] LAST_OVER = IDX_W'(OVER_NOTES - 1);

    localparam logic [SAMPLE_W-1:0] SAMPLE_POS = AMPLITUDE;
    localparam logic [SAMPLE_W-1:0] SAMPLE_NEG = ~AMPLITUDE + SAMPLE_W'(1);

    state_e             state, state_d;
    fx_e                fx, fx_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [SEG_W-1:0]   seg, seg_d;
    logic               restart_c;
    logic               play_c;
    logic [IDX_W-1:0]   last_idx_c;
    logic [HP_W-1:0]    hp_c;
    logic               phase;

    assign play_c     = (state == ST_PLAY);
    assign last_idx_c = (fx == FX_OVER) ? LAST_OVER : LAST_EAT;

    // Sequencer state, effect, note index, segment counter and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            fx    <= FX_NONE;
            idx   <= '0;
            seg   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            fx    <= fx_d;
            idx   <= idx_d;
            seg   <= seg_d;
            busy  <= (state_d != ST_IDLE);
        end
    end

    // Next-state logic: triggers take priority over any segment expiry
    always_comb begin
        state_d   = state;
        fx_d      = fx;
        idx_d     = idx;
        seg_d     = seg;
        restart_c = 1'b0;
        if (seg != '0) begin
            seg_d = seg - SEG_W'(1);
        end
        if (trig_over) begin
            state_d   = ST_PLAY;
            fx_d      = FX_OVER;
            idx_d     = '0;
            seg_d     = SEG_OVER;
            restart_c = 1'b1;
        end else if (trig_eat && (fx != FX_OVER)) begin
            state_d   = ST_PLAY;
            fx_d      = FX_EAT;
            idx_d     = '0;
            seg_d     = SEG_EAT;
            restart_c = 1'b1;
        end else begin
            case (state)
                ST_PLAY: begin
                    if (seg == '0) begin
                        if (idx != last_idx_c) begin
                            state_d = ST_GAP;
                            seg_d   = SEG_GAP;
                        end else begin
                            state_d = ST_IDLE;
                            fx_d    = FX_NONE;
                            idx_d   = '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (seg == '0) begin
                        state_d   = ST_PLAY;
                        idx_d     = idx + IDX_W'(1);
                        seg_d     = (fx == FX_OVER) ? SEG_OVER : SEG_EAT;
                        restart_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Half-period of the note being entered or currently playing
    always_comb begin
        hp_c = HP_C6;
        case (fx_d)
            FX_EAT: hp_c = (idx_d == IDX_W'(0)) ? HP_C6 : HP_E6;
            FX_OVER: begin
                case (idx_d)
                    2'd0:    hp_c = HP_G4;
                    2'd1:    hp_c = HP_E4;
                    2'd2:    hp_c = HP_C4;
                    default: hp_c = HP_C3;
                endcase
            end
            default: hp_c = HP_C6;
        endcase
    end

    tone_gen u_tone_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .half_period (hp_c),
        .restart     (restart_c),
        .enable      (play_c),
        .phase       (phase)
    );

    // Output sample register, one stage behind the sequencer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_left  <= '0;
            audio_right <= '0;
        end else if (mute || !play_c) begin
            audio_left  <= '0;
            audio_right <= '0;
        end else begin
            audio_left  <= phase ? SAMPLE_POS : SAMPLE_NEG;
            audio_right <= phase ? SAMPLE_POS : SAMPLE_NEG;
        end
    end

endmodule

// File: tb/tb_sfx_player.sv
// Self-checking bench for sfx_player with a time-since-trigger reference model.
module tb_sfx_player;

    localparam int unsigned CLK_HZ = 10_000;
    localparam int unsigned GAP_MS = 10;
    localparam int unsigned MS     = CLK_HZ / 1000;
    localparam logic [15:0] AMP    = 16'h1FFF;
    localparam logic [15:0] NEG    = 16'hE001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig_eat = 1'b0;
    logic        trig_over = 1'b0;
    logic        mute = 1'b0;
    logic [15:0] audio_left, audio_right;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: active effect (0 none, 1 eat, 2 over), cycles since its start, expected sample
    int          m_eff = 0;
    int          m_t   = 0;
    logic [15:0] m_audio = 16'h0000;

    always #5 clk = ~clk;

    sfx_player #(.CLK_HZ(CLK_HZ), .AMPLITUDE(AMP), .GAP_MS(GAP_MS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig_eat    (trig_eat),
        .trig_over   (trig_over),
        .mute        (mute),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .busy        (busy)
    );

    function automatic int n_notes(input int eff);
        return (eff == 2) ? 4 : 2;
    endfunction

    function automatic int freq(input int eff, input int i);
        if (eff == 2) begin
            case (i)
                0: return 392;
                1: return 330;
                2: return 262;
                default: return 131;
            endcase
        end
        return (i == 0) ? 1047 : 1319;
    endfunction

    function automatic int dur(input int eff);
        return ((eff == 2) ? 150 : 60) * MS;
    endfunction

    function automatic int total(input int eff);
        return n_notes(eff) * dur(eff) + (n_notes(eff) - 1) * GAP_MS * MS;
    endfunction

    // Ideal waveform level at cycle t of an effect
    function automatic logic [15:0] level(input int eff, input int t);
        int tt = t;
        for (int i = 0; i < n_notes(eff); i++) begin
            int hp = (CLK_HZ + freq(eff, i)) / (2 * freq(eff, i));
            if (tt < dur(eff)) return (((tt / hp) % 2) == 0) ? AMP : NEG;
            tt -= dur(eff);
            if (tt < GAP_MS * MS) return 16'h0000;
            tt -= GAP_MS * MS;
        end
        return 16'h0000;
    endfunction

    // Drive one cycle of inputs and advance the model across the clock edge
    task automatic tick(input logic e, input logic o, input logic m);
        trig_eat  = e;
        trig_over = o;
        mute      = m;
        @(posedge clk);
        m_audio = (m || m_eff == 0) ? 16'h0000 : level(m_eff, m_t);
        if (o) begin
            m_eff = 2; m_t = 0;
        end else if (e && m_eff != 2) begin
            m_eff = 1; m_t = 0;
        end else if (m_eff != 0) begin
            m_t++;
            if (m_t >= total(m_eff)) begin
                m_eff = 0; m_t = 0;
            end
        end
        @(negedge clk);
        trig_eat  = 1'b0;
        trig_over = 1'b0;
    endtask

    // Channels must match and only carry the three legal sample values
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (audio_left !== audio_right ||
                !(audio_left === 16'h0000 || audio_left === AMP || audio_left === NEG)) begin
                errors++;
                $display("FAIL sample_legal: left=%h right=%h", audio_left, audio_right);
            end
        end
    end

    task automatic test_reset();
        checks++;
        if (audio_left !== 16'h0000) begin
            errors++; $display("FAIL reset_audio: got %h exp 0000", audio_left);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b exp 0", busy);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_eat();
        int len = 0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            checks++;
            if (audio_left !== m_audio) begin
                errors++; $display("FAIL eat_audio c=%0d: got %h exp %h", c, audio_left, m_audio);
            end
            checks++;
            if (busy !== (m_eff != 0)) begin
                errors++; $display("FAIL eat_busy c=%0d: got %b exp %b", c, busy, m_eff != 0);
            end
            if ((len == 1 || len == 704) && audio_left !== AMP) begin
                errors++; $display("FAIL eat_pos len=%0d: got %h exp %h", len, audio_left, AMP);
            end
            if ((len == 6 || len == 705) && audio_left !== NEG) begin
                errors++; $display("FAIL eat_neg len=%0d: got %h exp %h", len, audio_left, NEG);
            end
            if (len == 650 && audio_left !== 16'h0000) begin
                errors++; $display("FAIL eat_gap: got %h exp 0000", audio_left);
            end
            if (!busy) break;
            len++;
            tick(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (len != 130 * MS) begin
            errors++; $display("FAIL eat_length: got %0d exp %0d", len, 130 * MS);
        end
    endtask

    task automatic test_simultaneous();
        int len = 0;
        tick(1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 10000; c++) begin
            checks++;
            if (audio_left !== m_audio) begin
                errors++; $display("FAIL simul_audio c=%0d: got %h exp %h", c, audio_left, m_audio);
            end
            checks++;
            if (busy !== (m_eff != 0)) begin
                errors++; $display("FAIL simul_busy c=%0d: got %b exp %b", c, busy, m_eff != 0);
            end
            if ((len == 1 || len == 13) && audio_left !== AMP) begin
                errors++; $display("FAIL simul_pos len=%0d: got %h exp %h", len, audio_left, AMP);
            end
            if (len == 14 && audio_left !== NEG) begin
                errors++; $display("FAIL simul_neg: got %h exp %h", audio_left, NEG);
            end
            if (!busy) break;
            len++;
            tick(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (len != 630 * MS) begin
            errors++; $display("FAIL simul_length: got %0d exp %0d", len, 630 * MS);
        end
    endtask

    task automatic test_retrigger(input logic over_again, input int exp_len);
        int len = 0;
        tick(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 10000; c++) begin
            checks++;
            if (audio_left !== m_audio) begin
                errors++; $display("FAIL retrig_audio o=%b c=%0d: got %h exp %h", over_again, c, audio_left, m_audio);
            end
            checks++;
            if (busy !== (m_eff != 0)) begin
                errors++; $display("FAIL retrig_busy o=%b c=%0d: got %b exp %b", over_again, c, busy, m_eff != 0);
            end
            if (!busy) break;
            len++;
            tick(len == 200 && !over_again, len == 200 && over_again, 1'b0);
        end
        checks++;
        if (len != exp_len) begin
            errors++; $display("FAIL retrig_length o=%b: got %0d exp %0d", over_again, len, exp_len);
        end
    endtask

    task automatic test_mute();
        int len = 0;
        tick(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            checks++;
            if (audio_left !== m_audio) begin
                errors++; $display("FAIL mute_audio c=%0d: got %h exp %h", c, audio_left, m_audio);
            end
            checks++;
            if (busy !== (m_eff != 0)) begin
                errors++; $display("FAIL mute_busy c=%0d: got %b exp %b", c, busy, m_eff != 0);
            end
            if (len == 101 && audio_left !== 16'h0000) begin
                errors++; $display("FAIL mute_on: got %h exp 0000", audio_left);
            end
            if (len == 400 && audio_left !== NEG) begin
                errors++; $display("FAIL mute_off: got %h exp %h", audio_left, NEG);
            end
            if (!busy) break;
            len++;
            tick(1'b0, 1'b0, len >= 100 && len < 400);
        end
        checks++;
        if (len != 130 * MS) begin
            errors++; $display("FAIL mute_length: got %0d exp %0d", len, 130 * MS);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 300; c++) tick(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (audio_left !== 16'h0000 || audio_right !== 16'h0000) begin
            errors++; $display("FAIL midreset_audio: got %h/%h exp 0000", audio_left, audio_right);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL midreset_busy: got %b exp 0", busy);
        end
        m_eff = 0; m_t = 0; m_audio = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (audio_left !== 16'h0000 || busy !== 1'b0) begin
                errors++; $display("FAIL postreset c=%0d: audio %h busy %b exp 0000/0", c, audio_left, busy);
            end
        end
    endtask

    task automatic test_random();
        logic rm = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            logic e, o;
            e = ($urandom_range(0, 299) == 0);
            o = ($urandom_range(0, 899) == 0);
            if ($urandom_range(0, 49) == 0) rm = ~rm;
            tick(e, o, rm);
            checks++;
            if (audio_left !== m_audio) begin
                errors++; $display("FAIL random_audio c=%0d: got %h exp %h", c, audio_left, m_audio);
            end
            checks++;
            if (busy !== (m_eff != 0)) begin
                errors++; $display("FAIL random_busy c=%0d: got %b exp %b", c, busy, m_eff != 0);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_eat();
        test_simultaneous();
        test_retrigger(1'b0, 630 * MS);
        test_retrigger(1'b1, 650 * MS);
        test_mute();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
